// File: rtl/bp_me_cce_id_to_cord_lut_pkg.sv
// Shared types for the CCE-ID to coherence-NoC cord lookup table.
// Contents: CCE region enum, lookup-table FSM state enum, and a macro that
// builds the packed {cid, y, x} table entry for given field widths.
package bp_me_cce_id_to_cord_lut_pkg;

  typedef enum logic [2:0] {
    e_cce_cc,
    e_cce_mc,
    e_cce_cac,
    e_cce_sac,
    e_cce_io
  } bp_cce_region_e;

  typedef enum logic {
    e_init,
    e_run
  } lut_state_e;

endpackage

// x occupies the low bits so the low x+y bits of an entry read directly as a cord.
`define BP_CCE_ENTRY_S(x_w, y_w, cid_w) \
  struct packed { \
    logic [cid_w-1:0] cid; \
    logic [y_w-1:0]   y; \
    logic [x_w-1:0]   x; \
  }

// File: rtl/bp_me_cce_id_to_cord_lut_if.sv
// Config-write and per-channel lookup/response bundle for the cord lookup table.
// Ports: cfg_* (single write port), lkup_* (request per channel),
// resp_* (registered response per channel), init_done_o (table ready).
interface bp_me_cce_id_to_cord_lut_if #(
  parameter int unsigned num_chan_p   = 2,
  parameter int unsigned id_width_p   = 4,
  parameter int unsigned cord_width_p = 8,
  parameter int unsigned cid_width_p  = 2
);

  logic                               init_done_o;

  logic                               cfg_v_i;
  logic [id_width_p-1:0]              cfg_id_i;
  logic [cord_width_p-1:0]            cfg_cord_i;
  logic [cid_width_p-1:0]             cfg_cid_i;
  logic                               cfg_ready_and_o;

  logic [num_chan_p-1:0]              lkup_v_i;
  logic [num_chan_p*id_width_p-1:0]   lkup_id_i;
  logic [num_chan_p-1:0]              lkup_ready_and_o;

  logic [num_chan_p-1:0]              resp_v_o;
  logic [num_chan_p*cord_width_p-1:0] resp_cord_o;
  logic [num_chan_p*cid_width_p-1:0]  resp_cid_o;
  logic [num_chan_p-1:0]              resp_err_o;
  logic [num_chan_p-1:0]              resp_ready_and_i;

  // master: the requester side (CSR logic and CCE routers)
  modport master (
    input  init_done_o, cfg_ready_and_o, lkup_ready_and_o,
           resp_v_o, resp_cord_o, resp_cid_o, resp_err_o,
    output cfg_v_i, cfg_id_i, cfg_cord_i, cfg_cid_i,
           lkup_v_i, lkup_id_i, resp_ready_and_i
  );

  // slave: the lookup table
  modport slave (
    output init_done_o, cfg_ready_and_o, lkup_ready_and_o,
           resp_v_o, resp_cord_o, resp_cid_o, resp_err_o,
    input  cfg_v_i, cfg_id_i, cfg_cord_i, cfg_cid_i,
           lkup_v_i, lkup_id_i, resp_ready_and_i
  );

endinterface

// File: rtl/bp_me_cce_id_to_cord_lut_default_cord.sv
// Combinational CCE ID -> default tiled-layout {x, y, cid}.
// Ports: id (CCE ID in), x / y / cid (default cord and concentrator ID out).
// Math is 32-bit and truncated to the field widths; IDs past the CC/MC/CAC/SAC
// bases fall into the IO region.
module bp_me_cce_default_cord
  import bp_me_cce_id_to_cord_lut_pkg::*;
#(
  parameter int unsigned cc_x_dim_p     = 2,
  parameter int unsigned cc_y_dim_p     = 2,
  parameter int unsigned ic_y_dim_p     = 1,
  parameter int unsigned sac_x_dim_p    = 1,
  parameter int unsigned num_core_p     = 4,
  parameter int unsigned num_l2e_p      = 2,
  parameter int unsigned num_cacc_p     = 2,
  parameter int unsigned num_sacc_p     = 2,
  parameter int unsigned id_width_p     = 4,
  parameter int unsigned x_cord_width_p = 4,
  parameter int unsigned y_cord_width_p = 4,
  parameter int unsigned cid_width_p    = 2
) (
  input  logic [id_width_p-1:0]     id,
  output logic [x_cord_width_p-1:0] x,
  output logic [y_cord_width_p-1:0] y,
  output logic [cid_width_p-1:0]    cid
);

  localparam int unsigned mc_base_lp  = num_core_p;
  localparam int unsigned cac_base_lp = mc_base_lp + num_l2e_p;
  localparam int unsigned sac_base_lp = cac_base_lp + num_cacc_p;
  localparam int unsigned io_base_lp  = sac_base_lp + num_sacc_p;

  bp_cce_region_e region;
  logic [31:0]    idv, j, x32, y32;

  always_comb begin
    idv    = 32'(id);
    region = e_cce_io;
    j      = idv - io_base_lp;
    if (idv < mc_base_lp) begin
      region = e_cce_cc;
      j      = idv;
    end else if (idv < cac_base_lp) begin
      region = e_cce_mc;
      j      = idv - mc_base_lp;
    end else if (idv < sac_base_lp) begin
      region = e_cce_cac;
      j      = idv - cac_base_lp;
    end else if (idv < io_base_lp) begin
      region = e_cce_sac;
      j      = idv - sac_base_lp;
    end

    x32 = '0;
    y32 = '0;
    case (region)
      e_cce_cc: begin
        x32 = sac_x_dim_p + j % cc_x_dim_p;
        y32 = ic_y_dim_p + j / cc_x_dim_p;
      end
      e_cce_mc: begin
        x32 = sac_x_dim_p + j % cc_x_dim_p;
        y32 = ic_y_dim_p + cc_y_dim_p + j / cc_x_dim_p;
      end
      // accelerator columns are filled top-to-bottom, so x steps with j/cc_y
      e_cce_cac: begin
        x32 = sac_x_dim_p + cc_x_dim_p + j / cc_y_dim_p;
        y32 = ic_y_dim_p + j % cc_y_dim_p;
      end
      e_cce_sac: begin
        x32 = j / cc_y_dim_p;
        y32 = ic_y_dim_p + j % cc_y_dim_p;
      end
      default: begin
        x32 = sac_x_dim_p + j % cc_x_dim_p;
        y32 = j / cc_x_dim_p;
      end
    endcase
  end

  assign x   = x32[x_cord_width_p-1:0];
  assign y   = y32[y_cord_width_p-1:0];
  assign cid = '0;

endmodule

// File: rtl/bp_me_cce_id_to_cord_lut.sv
// Runtime-programmable CCE ID -> {cord, cid} table with per-channel 1-cycle lookups.
// Ports: clk_i, reset_n_i (async active-low), bus (slave side of the lut interface).
// After reset a walker loads default cords (num_ids_lp cycles); then cfg writes
// override entries and each channel owns a one-entry response register.
module bp_me_cce_id_to_cord_lut
  import bp_me_cce_id_to_cord_lut_pkg::*;
#(
  parameter int unsigned cc_x_dim_p     = 2,
  parameter int unsigned cc_y_dim_p     = 2,
  parameter int unsigned ic_y_dim_p     = 1,
  parameter int unsigned sac_x_dim_p    = 1,
  parameter int unsigned num_core_p     = 4,
  parameter int unsigned num_l2e_p      = 2,
  parameter int unsigned num_cacc_p     = 2,
  parameter int unsigned num_sacc_p     = 2,
  parameter int unsigned num_io_p       = 2,
  parameter int unsigned id_width_p     = 4,
  parameter int unsigned x_cord_width_p = 4,
  parameter int unsigned y_cord_width_p = 4,
  parameter int unsigned cid_width_p    = 2,
  parameter int unsigned num_chan_p     = 2
) (
  input logic                         clk_i,
  input logic                         reset_n_i,
  bp_me_cce_id_to_cord_lut_if.slave   bus
);

  localparam int unsigned num_ids_lp =
    num_core_p + num_l2e_p + num_cacc_p + num_sacc_p + num_io_p;
  localparam int unsigned cord_width_lp = x_cord_width_p + y_cord_width_p;

  typedef `BP_CCE_ENTRY_S(x_cord_width_p, y_cord_width_p, cid_width_p) entry_s;

  lut_state_e            state;
  logic [id_width_p-1:0] walk_cnt;
  logic                  init_done;

  entry_s                tbl [num_ids_lp];

  logic [x_cord_width_p-1:0] dflt_x;
  logic [y_cord_width_p-1:0] dflt_y;
  logic [cid_width_p-1:0]    dflt_cid;

  bp_me_cce_default_cord #(
    .cc_x_dim_p    (cc_x_dim_p),
    .cc_y_dim_p    (cc_y_dim_p),
    .ic_y_dim_p    (ic_y_dim_p),
    .sac_x_dim_p   (sac_x_dim_p),
    .num_core_p    (num_core_p),
    .num_l2e_p     (num_l2e_p),
    .num_cacc_p    (num_cacc_p),
    .num_sacc_p    (num_sacc_p),
    .id_width_p    (id_width_p),
    .x_cord_width_p(x_cord_width_p),
    .y_cord_width_p(y_cord_width_p),
    .cid_width_p   (cid_width_p)
  ) u_default_cord (
    .id (walk_cnt),
    .x  (dflt_x),
    .y  (dflt_y),
    .cid(dflt_cid)
  );

  // Init walker: one default entry per cycle, then park in e_run.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= e_init;
      walk_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        e_init: begin
          walk_cnt <= walk_cnt + 1'b1;
          if (32'(walk_cnt) == num_ids_lp - 1) begin
            state     <= e_run;
            init_done <= 1'b1;
          end
        end
        default: init_done <= 1'b1;
      endcase
    end
  end

  assign bus.init_done_o     = init_done;
  assign bus.cfg_ready_and_o = init_done;

  // Single table write port: the walker owns it during init, cfg afterwards.
  // Out-of-range cfg IDs are accepted but never reach the table.
  logic                  tbl_we;
  logic [id_width_p-1:0] tbl_wr_idx;
  entry_s                tbl_wr_dat;

  always_comb begin
    tbl_we     = 1'b0;
    tbl_wr_idx = walk_cnt;
    tbl_wr_dat = entry_s'({dflt_cid, dflt_y, dflt_x});
    if (state == e_init) begin
      tbl_we = 1'b1;
    end else if (bus.cfg_v_i && init_done && (32'(bus.cfg_id_i) < num_ids_lp)) begin
      tbl_we     = 1'b1;
      tbl_wr_idx = bus.cfg_id_i;
      tbl_wr_dat = entry_s'({bus.cfg_cid_i, bus.cfg_cord_i});
    end
  end

  // Table contents are meaningless until the walker has run, so no reset.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < num_ids_lp; i++) begin
      if (tbl_we && (32'(tbl_wr_idx) == i)) tbl[i] <= tbl_wr_dat;
    end
  end

  for (genvar ch = 0; ch < num_chan_p; ch++) begin : g_chan
    logic [id_width_p-1:0] id;
    logic                  in_range;
    logic                  ready;
    logic                  accept;
    entry_s                rd;
    logic                  resp_v;
    logic                  resp_err;
    entry_s                resp_dat;

    assign id       = bus.lkup_id_i[ch*id_width_p +: id_width_p];
    assign in_range = 32'(id) < num_ids_lp;
    assign ready    = init_done & (~resp_v | bus.resp_ready_and_i[ch]);
    assign accept   = bus.lkup_v_i[ch] & ready;

    // Reads the pre-edge table, so a same-cycle cfg write is not seen.
    always_comb begin
      rd = '0;
      for (int unsigned i = 0; i < num_ids_lp; i++) begin
        if (32'(id) == i) rd = tbl[i];
      end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        resp_v   <= 1'b0;
        resp_err <= 1'b0;
        resp_dat <= '0;
      end else if (accept) begin
        resp_v   <= 1'b1;
        resp_err <= ~in_range;
        resp_dat <= in_range ? rd : '0;
      end else if (bus.resp_ready_and_i[ch]) begin
        resp_v   <= 1'b0;
      end
    end

    assign bus.lkup_ready_and_o[ch]                          = ready;
    assign bus.resp_v_o[ch]                                  = resp_v;
    assign bus.resp_err_o[ch]                                = resp_err;
    assign bus.resp_cord_o[ch*cord_width_lp +: cord_width_lp] = resp_dat[cord_width_lp-1:0];
    assign bus.resp_cid_o[ch*cid_width_p +: cid_width_p]      = resp_dat.cid;
  end

endmodule

// File: tb/tb_bp_me_cce_id_to_cord_lut.sv
// Directed bench for the CCE-ID to cord lookup table at default parameters.
// Cords are shown as {y, x} nibbles, e.g. x=2,y=3 -> 8'h32.
module tb_bp_me_cce_id_to_cord_lut;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bp_me_cce_id_to_cord_lut_if #(
    .num_chan_p(2), .id_width_p(4), .cord_width_p(8), .cid_width_p(2)
  ) bus ();

  bp_me_cce_id_to_cord_lut dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .bus      (bus)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.init_done_o, bus.cfg_ready_and_o, bus.lkup_ready_and_o} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 0000",
               {bus.init_done_o, bus.cfg_ready_and_o, bus.lkup_ready_and_o});
    end
    checks++;
    if ({bus.resp_v_o, bus.resp_err_o} !== 4'b0) begin
      failures++;
      $display("FAIL reset_resp_flags: got %b expected 0000", {bus.resp_v_o, bus.resp_err_o});
    end
    checks++;
    if ({bus.resp_cord_o, bus.resp_cid_o} !== 20'h0) begin
      failures++;
      $display("FAIL reset_resp_data: got %h expected 0", {bus.resp_cord_o, bus.resp_cid_o});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    for (int k = 1; k <= 12; k++) begin
      logic [3:0] exp;
      @(posedge clk); #1;
      exp = (k == 12) ? 4'b1111 : 4'b0000;
      checks++;
      if ({bus.init_done_o, bus.cfg_ready_and_o, bus.lkup_ready_and_o} !== exp) begin
        failures++;
        $display("FAIL init_cycle%0d: got %b expected %b", k,
                 {bus.init_done_o, bus.cfg_ready_and_o, bus.lkup_ready_and_o}, exp);
      end
    end
  endtask

  task automatic test_lookup();
    logic [3:0] ids   [7] = '{4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd12, 4'd15};
    logic [7:0] cords [7] = '{8'h22, 8'h32, 8'h23, 8'h20, 8'h02, 8'h00, 8'h00};
    logic       errs  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.resp_ready_and_i = 2'b11;
    checks++;
    if (bus.resp_v_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL lookup_idle_v: got %b expected 0", bus.resp_v_o[0]);
    end
    for (int i = 0; i < 7; i++) begin
      bus.lkup_v_i[0]     = 1'b1;
      bus.lkup_id_i[3:0]  = ids[i];
      #1;
      checks++;
      if (bus.lkup_ready_and_o[0] !== 1'b1) begin
        failures++;
        $display("FAIL lookup_ready id%0d: got %b expected 1", ids[i], bus.lkup_ready_and_o[0]);
      end
      @(posedge clk); #1;
      bus.lkup_v_i[0] = 1'b0;
      checks++;
      if ({bus.resp_v_o[0], bus.resp_err_o[0], bus.resp_cord_o[7:0], bus.resp_cid_o[1:0]}
          !== {1'b1, errs[i], cords[i], 2'b00}) begin
        failures++;
        $display("FAIL lookup id%0d: got v=%b err=%b cord=%h cid=%h expected v=1 err=%b cord=%h cid=0",
                 ids[i], bus.resp_v_o[0], bus.resp_err_o[0], bus.resp_cord_o[7:0],
                 bus.resp_cid_o[1:0], errs[i], cords[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_read_before_write();
    bus.cfg_v_i         = 1'b1;
    bus.cfg_id_i        = 4'd3;
    bus.cfg_cord_i      = 8'h65;
    bus.cfg_cid_i       = 2'd1;
    bus.lkup_v_i[1]     = 1'b1;
    bus.lkup_id_i[7:4]  = 4'd3;
    #1;
    checks++;
    if ({bus.cfg_ready_and_o, bus.lkup_ready_and_o[1]} !== 2'b11) begin
      failures++;
      $display("FAIL rbw_ready: got %b expected 11", {bus.cfg_ready_and_o, bus.lkup_ready_and_o[1]});
    end
    @(posedge clk); #1;
    bus.cfg_v_i = 1'b0;
    checks++;
    if ({bus.resp_v_o[1], bus.resp_cord_o[15:8], bus.resp_cid_o[3:2]} !== {1'b1, 8'h22, 2'd0}) begin
      failures++;
      $display("FAIL rbw_old: got v=%b cord=%h cid=%h expected v=1 cord=22 cid=0",
               bus.resp_v_o[1], bus.resp_cord_o[15:8], bus.resp_cid_o[3:2]);
    end
    @(posedge clk); #1;
    bus.lkup_v_i[1] = 1'b0;
    checks++;
    if ({bus.resp_v_o[1], bus.resp_cord_o[15:8], bus.resp_cid_o[3:2]} !== {1'b1, 8'h65, 2'd1}) begin
      failures++;
      $display("FAIL rbw_new: got v=%b cord=%h cid=%h expected v=1 cord=65 cid=1",
               bus.resp_v_o[1], bus.resp_cord_o[15:8], bus.resp_cid_o[3:2]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [3:0] ids   [4] = '{4'd6, 4'd7, 4'd8, 4'd9};
    logic [7:0] cords [4] = '{8'h13, 8'h23, 8'h10, 8'h20};
    bus.resp_ready_and_i = 2'b10;
    bus.lkup_v_i         = 2'b11;
    bus.lkup_id_i[3:0]   = 4'd5;
    bus.lkup_id_i[7:4]   = ids[0];
    @(posedge clk); #1;
    bus.lkup_v_i[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({bus.resp_v_o[0], bus.resp_cord_o[7:0], bus.lkup_ready_and_o[0]} !== {1'b1, 8'h32, 1'b0}) begin
        failures++;
        $display("FAIL stall_ch0 cyc%0d: got v=%b cord=%h rdy=%b expected v=1 cord=32 rdy=0",
                 k, bus.resp_v_o[0], bus.resp_cord_o[7:0], bus.lkup_ready_and_o[0]);
      end
      checks++;
      if ({bus.resp_v_o[1], bus.resp_cord_o[15:8], bus.lkup_ready_and_o[1]} !== {1'b1, cords[k], 1'b1}) begin
        failures++;
        $display("FAIL stream_ch1 cyc%0d: got v=%b cord=%h rdy=%b expected v=1 cord=%h rdy=1",
                 k, bus.resp_v_o[1], bus.resp_cord_o[15:8], bus.lkup_ready_and_o[1], cords[k]);
      end
      if (k < 3) bus.lkup_id_i[7:4] = ids[k+1];
      else       bus.lkup_v_i[1] = 1'b0;
      @(posedge clk); #1;
    end
    bus.resp_ready_and_i = 2'b11;
    @(posedge clk); #1;
    checks++;
    if (bus.resp_v_o !== 2'b00) begin
      failures++;
      $display("FAIL drain: got %b expected 00", bus.resp_v_o);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bus.resp_ready_and_i = 2'b00;
    bus.lkup_v_i[0]      = 1'b1;
    bus.lkup_id_i[3:0]   = 4'd3;
    @(posedge clk); #1;
    bus.lkup_v_i[0] = 1'b0;
    checks++;
    if ({bus.resp_v_o[0], bus.resp_cord_o[7:0]} !== {1'b1, 8'h65}) begin
      failures++;
      $display("FAIL pre_reset_resp: got v=%b cord=%h expected v=1 cord=65",
               bus.resp_v_o[0], bus.resp_cord_o[7:0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.init_done_o, bus.cfg_ready_and_o, bus.lkup_ready_and_o, bus.resp_v_o,
         bus.resp_err_o, bus.resp_cord_o, bus.resp_cid_o} !== 28'h0) begin
      failures++;
      $display("FAIL reset_mid_resp: got %h expected 0",
               {bus.init_done_o, bus.cfg_ready_and_o, bus.lkup_ready_and_o, bus.resp_v_o,
                bus.resp_err_o, bus.resp_cord_o, bus.resp_cid_o});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.init_done_o, bus.cfg_ready_and_o, bus.lkup_ready_and_o, bus.resp_v_o,
         bus.resp_err_o, bus.resp_cord_o, bus.resp_cid_o} !== 28'h0) begin
      failures++;
      $display("FAIL reset_mid_init: got %h expected 0",
               {bus.init_done_o, bus.cfg_ready_and_o, bus.lkup_ready_and_o, bus.resp_v_o,
                bus.resp_err_o, bus.resp_cord_o, bus.resp_cid_o});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0;
    while (bus.init_done_o !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != 12) begin
      failures++;
      $display("FAIL reinit_cycles: got %0d expected 12", cyc);
    end
    bus.resp_ready_and_i = 2'b11;
    bus.lkup_v_i[0]      = 1'b1;
    bus.lkup_id_i[3:0]   = 4'd3;
    @(posedge clk); #1;
    bus.lkup_v_i[0] = 1'b0;
    checks++;
    if ({bus.resp_v_o[0], bus.resp_cord_o[7:0], bus.resp_cid_o[1:0]} !== {1'b1, 8'h22, 2'd0}) begin
      failures++;
      $display("FAIL revert_id3: got v=%b cord=%h cid=%h expected v=1 cord=22 cid=0",
               bus.resp_v_o[0], bus.resp_cord_o[7:0], bus.resp_cid_o[1:0]);
    end
  endtask

  initial begin
    bus.cfg_v_i          = 1'b0;
    bus.cfg_id_i         = '0;
    bus.cfg_cord_i       = '0;
    bus.cfg_cid_i        = '0;
    bus.lkup_v_i         = '0;
    bus.lkup_id_i        = '0;
    bus.resp_ready_and_i = '0;
    test_reset();
    test_init();
    test_lookup();
    test_read_before_write();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
